muldiv_ctrl: RTL and testbench

//  Sequencer for the EX-stage HI/LO unit of the pipelined MIPS core. Accepts

---
 rtl/mips_pkg.sv | 14 +
 rtl/muldiv_ctrl_if.sv | 18 +
 rtl/md_step.sv | 19 +
 rtl/muldiv_ctrl.sv | 114 +++++++++++
 tb/tb_muldiv_ctrl.sv | 124 ++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared HI/LO unit encodings for the EX stage.
package mips_pkg;
    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;
endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EX-stage request/result bundle for the HI/LO unit.
interface muldiv_ctrl_if #(parameter int WIDTH = 32);
    logic             StartE;
    logic [1:0]       MdOpE;
    logic [WIDTH-1:0] SrcAE;
    logic [WIDTH-1:0] SrcBE;
    logic             MtHiE;
    logic             MtLoE;
    logic             AbortE;
    logic             BusyE;
    logic             DoneE;
    logic [WIDTH-1:0] HiE;
    logic [WIDTH-1:0] LoE;
    modport master (output StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE, AbortE,
                    input BusyE, DoneE, HiE, LoE);
    modport slave (input StartE, MdOpE, SrcAE, SrcBE, MtHiE, MtLoE, AbortE,
                   output BusyE, DoneE, HiE, LoE);
endinterface

// File: rtl/md_step.sv
// md_step: one shift-add multiply or restoring-divide iteration.
module md_step #(parameter int WIDTH = 32) (
    input  logic             mul,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] op,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] add, r_sh, diff;
    logic ge;
    assign add  = lo_i[0] ? {1'b0, hi_i} + {1'b0, op} : {1'b0, hi_i};
    assign r_sh = {hi_i, lo_i[WIDTH-1]};
    assign diff = r_sh - {1'b0, op};
    // partial remainder stays below the divisor, so the diff MSB is the borrow
    assign ge   = ~diff[WIDTH];
    assign hi_o = mul ? add[WIDTH:1] : (ge ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0]);
    assign lo_o = mul ? {add[0], lo_i[WIDTH-1:1]} : {lo_i[WIDTH-2:0], ge};
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative MULT/DIV sequencer owning the HI/LO registers.
module muldiv_ctrl
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input logic clk,
    input logic reset,
    muldiv_ctrl_if.slave bus
);
    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_q, mul_d, negq_q, negq_d, negr_q, negr_d, done_q, done_d;
    logic [WIDTH-1:0] op_q, op_d, hacc_q, hacc_d, lacc_q, lacc_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] hstep, lstep, abs_a, abs_b;
    logic [2*WIDTH-1:0] prod;
    logic             mul, sgn, launch;
    assign mul    = bus.MdOpE == MD_MULT || bus.MdOpE == MD_MULTU;
    assign sgn    = bus.MdOpE == MD_MULT || bus.MdOpE == MD_DIV;
    assign abs_a  = sgn && bus.SrcAE[WIDTH-1] ? -bus.SrcAE : bus.SrcAE;
    assign abs_b  = sgn && bus.SrcBE[WIDTH-1] ? -bus.SrcBE : bus.SrcBE;
    assign launch = bus.StartE && !bus.AbortE;
    assign prod   = negq_q ? -{hacc_q, lacc_q} : {hacc_q, lacc_q};
    // mul: op = multiplicand, lacc = multiplier; div: op = divisor, lacc = dividend
    md_step #(.WIDTH(WIDTH)) u_step (
        .mul (mul_q),
        .hi_i(hacc_q),
        .lo_i(lacc_q),
        .op  (op_q),
        .hi_o(hstep),
        .lo_o(lstep)
    );
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mul_d   = mul_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        op_d    = op_q;
        hacc_d  = hacc_q;
        lacc_d  = lacc_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            MD_IDLE: begin
                if (launch) begin
                    state_d = MD_CALC;
                    cnt_d   = '0;
                    mul_d   = mul;
                    negq_d  = sgn && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
                    negr_d  = sgn && bus.SrcAE[WIDTH-1];
                    op_d    = mul ? abs_a : abs_b;
                    hacc_d  = '0;
                    lacc_d  = mul ? abs_b : abs_a;
                end else if (!bus.StartE) begin
                    hi_d = bus.MtHiE ? bus.SrcAE : hi_q;
                    lo_d = bus.MtLoE ? bus.SrcAE : lo_q;
                end
            end
            MD_CALC: begin
                if (bus.AbortE) begin
                    state_d = MD_IDLE;
                end else begin
                    hacc_d  = hstep;
                    lacc_d  = lstep;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = cnt_q == CNT_W'(WIDTH - 1) ? MD_FIX : MD_CALC;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (!bus.AbortE) begin
                    hi_d   = mul_q ? prod[2*WIDTH-1:WIDTH] : (negr_q ? -hacc_q : hacc_q);
                    lo_d   = mul_q ? prod[WIDTH-1:0] : (negq_q ? -lacc_q : lacc_q);
                    done_d = 1'b1;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            mul_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            op_q    <= '0;
            hacc_q  <= '0;
            lacc_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mul_q   <= mul_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            op_q    <= op_d;
            hacc_q  <= hacc_d;
            lacc_q  <= lacc_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end
    assign bus.BusyE = state_q != MD_IDLE;
    assign bus.DoneE = done_q;
    assign bus.HiE   = hi_q;
    assign bus.LoE   = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed vector table plus corner-case sequences for muldiv_ctrl.
module tb_muldiv_ctrl;
    import mips_pkg::*;
    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_vec = 0;
    int n_err = 0;
    vec_t vt[12];
    muldiv_ctrl_if #(.WIDTH(32)) bus ();
    muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask
    task automatic mt(input logic h, input logic l, input logic [31:0] v);
        @(negedge clk);
        bus.MtHiE = h;
        bus.MtLoE = l;
        bus.SrcAE = v;
        @(negedge clk);
        bus.MtHiE = 1'b0;
        bus.MtLoE = 1'b0;
    endtask
    // kind: 0 plain, 1 MTLO at busy cycle k, 2 abort at k, 3 reset at k
    task automatic run(input string nm, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int k, input int kind,
                       input logic [31:0] ehi, input logic [31:0] elo);
        int n;
        @(negedge clk);
        bus.MdOpE  = op;
        bus.SrcAE  = a;
        bus.SrcBE  = b;
        bus.StartE = 1'b1;
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.SrcAE  = $urandom;
        bus.SrcBE  = $urandom;
        n = 0;
        while (bus.BusyE && n < 100) begin
            n++;
            if (n == k) begin
                bus.MtLoE  = kind == 1;
                bus.AbortE = kind == 2;
                reset      = kind == 3;
            end
            @(negedge clk);
            bus.MtLoE  = 1'b0;
            bus.AbortE = 1'b0;
            reset      = 1'b0;
        end
        if (kind < 2) begin
            chk({nm, " busy_cycles"}, n, 33);
            chk({nm, " done"}, {31'b0, bus.DoneE}, 1);
            chk({nm, " hi"}, bus.HiE, ehi);
            chk({nm, " lo"}, bus.LoE, elo);
            @(negedge clk);
            chk({nm, " done_pulse"}, {31'b0, bus.DoneE}, 0);
        end else begin
            chk({nm, " busy_cycles"}, n, k);
            chk({nm, " no_done"}, {31'b0, bus.DoneE}, 0);
            chk({nm, " hi"}, bus.HiE, ehi);
            chk({nm, " lo"}, bus.LoE, elo);
            if (kind == 3) chk({nm, " state"}, {30'b0, dut.state_q}, {30'b0, MD_IDLE});
        end
    endtask
    initial begin
        vt[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vt[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
        vt[2]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vt[3]  = '{MD_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};
        vt[4]  = '{MD_MULTU, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C};
        vt[5]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vt[6]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
        vt[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vt[8]  = '{MD_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
        vt[9]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
        vt[10] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vt[11] = '{MD_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        bus.StartE = 1'b0;
        bus.MdOpE  = 2'b00;
        bus.SrcAE  = '0;
        bus.SrcBE  = '0;
        bus.MtHiE  = 1'b0;
        bus.MtLoE  = 1'b0;
        bus.AbortE = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", {31'b0, bus.BusyE}, 0);
        chk("reset done", {31'b0, bus.DoneE}, 0);
        chk("reset hi", bus.HiE, 0);
        chk("reset lo", bus.LoE, 0);
        for (int i = 0; i < 12; i++) run($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, 0, 0, vt[i].hi, vt[i].lo);
        mt(1'b1, 1'b0, 32'h1234);
        chk("mthi", bus.HiE, 32'h1234);
        run("mtlo_busy", MD_MULTU, 3, 4, 5, 1, 32'h0, 32'hC);
        mt(1'b1, 1'b0, 32'hAA);
        mt(1'b0, 1'b1, 32'hBB);
        chk("preload hi", bus.HiE, 32'hAA);
        chk("preload lo", bus.LoE, 32'hBB);
        run("abort", MD_DIVU, 100, 7, 10, 2, 32'hAA, 32'hBB);
        run("relaunch", MD_DIVU, 100, 7, 0, 0, 32'h2, 32'hE);
        run("abort_fix", MD_MULTU, 5, 5, 33, 2, 32'h2, 32'hE);
        run("reset_mid", MD_MULT, 32'hFFFFFFFD, 5, 20, 3, 32'h0, 32'h0);
        @(negedge clk);
        bus.StartE = 1'b1;
        bus.AbortE = 1'b1;
        @(negedge clk);
        bus.StartE = 1'b0;
        bus.AbortE = 1'b0;
        chk("start_abort busy", {31'b0, bus.BusyE}, 0);
        @(negedge clk);
        chk("start_abort done", {31'b0, bus.DoneE}, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
